// File: rtl/median_event_detector_if.sv
// Bus between the filter side and median_event_detector.
// The filter/control side drives the sample and the count clear. The detector drives the
// level, the edge pulses and the episode statistics.
interface median_event_detector_if #(
   parameter int R_WIDTH = 8,
   parameter int CNT_W   = 16
);
   logic [R_WIDTH-1:0] X;
   logic               X_VALID;
   logic               CLR_CNT;
   logic               LEVEL;
   logic               RISE;
   logic               FALL;
   logic [CNT_W-1:0]   EVT_CNT;
   logic [R_WIDTH-1:0] PEAK;
   logic [CNT_W-1:0]   DUR;

   modport master (
      output X, X_VALID, CLR_CNT,
      input  LEVEL, RISE, FALL, EVT_CNT, PEAK, DUR
   );

   modport slave (
      input  X, X_VALID, CLR_CNT,
      output LEVEL, RISE, FALL, EVT_CNT, PEAK, DUR
   );
endinterface

// File: rtl/median_event_detector.sv
// median_event_detector: hysteresis and debounce on the filtered sample stream.
// The detector reports a level flag, one-cycle rise and fall pulses, and a saturating count of
// rising events. When a high episode completes, it also reports the peak sample and the
// duration of that episode.
module median_event_detector #(
   parameter int R_WIDTH = 8,
   parameter int HI_TH   = 160,
   parameter int LO_TH   = 96,
   parameter int HOLD    = 4,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   srst_n,
   median_event_detector_if.slave bus
);

   typedef enum logic [1:0] {S_LOW, S_ARM_HI, S_HIGH, S_ARM_LO} state_t;

   localparam logic [R_WIDTH-1:0] HI_V    = R_WIDTH'(HI_TH);
   localparam logic [R_WIDTH-1:0] LO_V    = R_WIDTH'(LO_TH);
   localparam logic [CNT_W-1:0]   HOLD_M1 = CNT_W'(HOLD - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;
   localparam logic [CNT_W-1:0]   ONE     = CNT_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   run_q, run_d;
   logic               level_q, level_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic [CNT_W-1:0]   evt_q, evt_d;
   logic [R_WIDTH-1:0] peak_run_q, peak_run_d;
   logic [CNT_W-1:0]   dur_run_q, dur_run_d;
   logic [R_WIDTH-1:0] peak_q, peak_d;
   logic [CNT_W-1:0]   dur_q, dur_d;

   logic               hi_w, lo_w;
   logic [R_WIDTH-1:0] peak_max_w;
   logic [CNT_W-1:0]   dur_inc_w;
   logic [CNT_W-1:0]   evt_inc_w;

   assign hi_w       = (bus.X >= HI_V);
   assign lo_w       = (bus.X <= LO_V);
   assign peak_max_w = (bus.X > peak_run_q) ? bus.X : peak_run_q;
   assign dur_inc_w  = (dur_run_q == CNT_MAX) ? dur_run_q : dur_run_q + ONE;
   assign evt_inc_w  = (evt_q == CNT_MAX) ? evt_q : evt_q + ONE;

   // Next-state logic. Only valid samples advance the FSM. The edge pulses default to low,
   // so they last for exactly one cycle.
   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      level_d    = level_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      evt_d      = evt_q;
      peak_run_d = peak_run_q;
      dur_run_d  = dur_run_q;
      peak_d     = peak_q;
      dur_d      = dur_q;

      if (bus.X_VALID) begin
         case (state_q)
            S_LOW: begin
               if (hi_w) begin
                  if (HOLD == 1) rise_d = 1'b1;
                  else begin
                     state_d = S_ARM_HI;
                     run_d   = ONE;
                  end
               end
            end
            S_ARM_HI: begin
               if (!hi_w) begin
                  state_d = S_LOW;
                  run_d   = '0;
               end else if (run_q == HOLD_M1) rise_d = 1'b1;
               else run_d = run_q + ONE;
            end
            S_HIGH: begin
               if (lo_w) begin
                  if (HOLD == 1) fall_d = 1'b1;
                  else begin
                     state_d = S_ARM_LO;
                     run_d   = ONE;
                  end
               end
            end
            default: begin // S_ARM_LO
               if (!lo_w) begin
                  state_d = S_HIGH;
                  run_d   = '0;
               end else if (run_q == HOLD_M1) fall_d = 1'b1;
               else run_d = run_q + ONE;
            end
         endcase

         // Episode trackers follow every valid sample while the level is high.
         if (level_q) begin
            peak_run_d = peak_max_w;
            dur_run_d  = dur_inc_w;
         end

         if (rise_d) begin
            state_d    = S_HIGH;
            run_d      = '0;
            level_d    = 1'b1;
            evt_d      = evt_inc_w;
            peak_run_d = bus.X;
            dur_run_d  = '0;
         end

         // On a fall, the completing sample still counts toward the peak and the duration.
         if (fall_d) begin
            state_d = S_LOW;
            run_d   = '0;
            level_d = 1'b0;
            peak_d  = peak_max_w;
            dur_d   = dur_inc_w;
         end
      end

      // A clear in the same cycle as a rise keeps that rise in the count.
      if (bus.CLR_CNT) evt_d = rise_d ? ONE : '0;
   end

   // State and output registers. An asynchronous reset discards any open episode.
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_q    <= S_LOW;
         run_q      <= '0;
         level_q    <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         evt_q      <= '0;
         peak_run_q <= '0;
         dur_run_q  <= '0;
         peak_q     <= '0;
         dur_q      <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         level_q    <= level_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         evt_q      <= evt_d;
         peak_run_q <= peak_run_d;
         dur_run_q  <= dur_run_d;
         peak_q     <= peak_d;
         dur_q      <= dur_d;
      end
   end

   assign bus.LEVEL   = level_q;
   assign bus.RISE    = rise_q;
   assign bus.FALL    = fall_q;
   assign bus.EVT_CNT = evt_q;
   assign bus.PEAK    = peak_q;
   assign bus.DUR     = dur_q;

endmodule
